// File: rtl/regs_wb_arbiter.sv
// Round-robin writeback arbiter sharing the register file's single write port among ALU, MEM and MDU.
// Optional hazard query ports are built when WB_SCOREBOARD_EN is defined.
module regs_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    output logic              Write_Reg,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic [15:0]       wr_count
`ifdef WB_SCOREBOARD_EN
    ,
    input  logic [ADDR_W-1:0] q_addr_a,
    input  logic [ADDR_W-1:0] q_addr_b,
    output logic              hazard_a,
    output logic              hazard_b
`endif
);

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_MDU = 2'd2
    } src_e;

    src_e              last;
    src_e              winner;
    logic              grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Search begins just after the last winner; the first valid requester wins.
    always_comb begin
        grant  = 1'b0;
        winner = SRC_ALU;
        unique case (last)
            SRC_ALU: begin
                if (mem_valid)      begin grant = 1'b1; winner = SRC_MEM; end
                else if (mdu_valid) begin grant = 1'b1; winner = SRC_MDU; end
                else if (alu_valid) begin grant = 1'b1; winner = SRC_ALU; end
            end
            SRC_MEM: begin
                if (mdu_valid)      begin grant = 1'b1; winner = SRC_MDU; end
                else if (alu_valid) begin grant = 1'b1; winner = SRC_ALU; end
                else if (mem_valid) begin grant = 1'b1; winner = SRC_MEM; end
            end
            default: begin
                if (alu_valid)      begin grant = 1'b1; winner = SRC_ALU; end
                else if (mem_valid) begin grant = 1'b1; winner = SRC_MEM; end
                else if (mdu_valid) begin grant = 1'b1; winner = SRC_MDU; end
            end
        endcase
    end

    always_comb begin
        sel_addr = alu_addr;
        sel_data = alu_data;
        unique case (winner)
            SRC_MEM: begin sel_addr = mem_addr; sel_data = mem_data; end
            SRC_MDU: begin sel_addr = mdu_addr; sel_data = mdu_data; end
            default: begin sel_addr = alu_addr; sel_data = alu_data; end
        endcase
    end

    always_comb begin
        alu_ready = grant && (winner == SRC_ALU) && !Reset;
        mem_ready = grant && (winner == SRC_MEM) && !Reset;
        mdu_ready = grant && (winner == SRC_MDU) && !Reset;
    end

    // Writes to r0 are accepted (requester sees ready) but never reach the file.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            last      <= SRC_MDU;
            Write_Reg <= 1'b0;
            W_Addr    <= '0;
            W_Data    <= '0;
            wr_count  <= '0;
        end else if (grant) begin
            last      <= winner;
            Write_Reg <= (sel_addr != '0);
            W_Addr    <= sel_addr;
            W_Data    <= sel_data;
            if ((sel_addr != '0) && (wr_count != 16'hFFFF))
                wr_count <= wr_count + 16'd1;
        end else begin
            Write_Reg <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    always_comb begin
        hazard_a = (q_addr_a != '0) &&
                   ((alu_valid && (alu_addr == q_addr_a)) ||
                    (mem_valid && (mem_addr == q_addr_a)) ||
                    (mdu_valid && (mdu_addr == q_addr_a)) ||
                    (Write_Reg && (W_Addr == q_addr_a)));
        hazard_b = (q_addr_b != '0) &&
                   ((alu_valid && (alu_addr == q_addr_b)) ||
                    (mem_valid && (mem_addr == q_addr_b)) ||
                    (mdu_valid && (mdu_addr == q_addr_b)) ||
                    (Write_Reg && (W_Addr == q_addr_b)));
    end
`endif

endmodule
